// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg -- shared types and constants for the instruction fetch unit.
//   PC_W / INSTR_W : fetch address and instruction widths
//   NOP            : instruction presented when the fetch buffer is empty
//   fetch_state_e  : fetch FSM states
//   fetch_entry_t  : one fetch-buffer entry {pc, instr}
package if_fetch_unit_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch step; wraps naturally at the address width.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if -- instruction-memory request/acknowledge channel.
//   imem_req   : request, held until acknowledged (master -> slave)
//   imem_addr  : byte address of the request       (master -> slave)
//   imem_ack   : read complete, rdata valid        (slave -> master)
//   imem_rdata : instruction word                  (slave -> master)
interface if_fetch_unit_if;

    logic                                    imem_req;
    logic [if_fetch_unit_pkg::PC_W-1:0]      imem_addr;
    logic                                    imem_ack;
    logic [if_fetch_unit_pkg::INSTR_W-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo -- two-entry {pc, instr} FIFO feeding the decode stage.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : advance the head (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   push_entry : entry to write
//   head       : current head entry, {0, NOP} when empty
//   count      : number of valid entries (0..2)
module fetch_fifo
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        head.pc    = '0;
        head.instr = NOP;
        if (count != 2'd0) head = mem[rd_ptr];
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction fetch with a two-entry fetch buffer.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   le               : decode takes the buffer head this cycle
//   redirect         : restart fetch at redirect_target, flushing the buffer
//   redirect_target  : new fetch byte address
//   imem             : instruction-memory channel (master side)
//   instr_out/pc_out : buffer head, NOP / 0 when empty
//   instr_valid      : buffer non-empty
// One request is outstanding at most. A redirect while a request is in
// flight parks the FSM in DISCARD until the stale reply arrives.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 9'h000,
    parameter int              BUF_DEPTH = 2     // only 2 is supported
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                le,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_target,
    if_fetch_unit_if.master     imem,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [PC_W-1:0]     pc_out,
    output logic                instr_valid
);

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    fetch_state_e    state, state_next;
    logic [PC_W-1:0] fetch_pc, fetch_pc_next;
    logic [PC_W-1:0] req_addr;
    logic            req;
    logic            issue;
    logic            push;
    logic [1:0]      count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            // Latched at issue so DISCARD can keep presenting the abandoned
            // address after fetch_pc has moved to the redirect target.
            if (issue) req_addr <= fetch_pc;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req           = 1'b0;
        issue         = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                // imem_ack here belongs to no live request and is ignored.
                if (redirect) begin
                    fetch_pc_next = redirect_target;
                end else if (count < BUF_FULL) begin
                    req        = 1'b1;
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (redirect) begin
                    fetch_pc_next = redirect_target;
                    state_next    = imem.imem_ack ? IDLE : DISCARD;
                end else if (imem.imem_ack) begin
                    push          = 1'b1;
                    fetch_pc_next = next_pc(fetch_pc);
                    state_next    = IDLE;
                end
            end
            DISCARD: begin
                req = 1'b1;
                if (redirect)      fetch_pc_next = redirect_target;
                if (imem.imem_ack) state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The IDLE request is combinational, so gate it while reset is held.
    assign imem.imem_req  = req && !reset;
    assign imem.imem_addr = (state == IDLE) ? fetch_pc : req_addr;

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = imem.imem_rdata;

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (le),
        .flush      (redirect),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign instr_out   = head.instr;
    assign pc_out      = head.pc;
    assign instr_valid = (count != 2'd0);

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit -- randomized bench with a queue-based reference model.
// The stimulus process plays decode and instruction memory, and keeps the
// expected fetch-buffer contents as a queue of {pc, instr}; the monitor
// compares the buffer head against the queue front every cycle.
module tb_if_fetch_unit;

    localparam logic [8:0] RESET_PC = 9'h000;
    localparam int         NCYC     = 600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        le = 1'b0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_target = 9'h000;
    logic [31:0] instr_out;
    logic [8:0]  pc_out;
    logic        instr_valid;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .le              (le),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (imem),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8:0] pick_target();
        logic [6:0] w;
        w = 7'($urandom_range(0, 127));
        case ($urandom_range(0, 4))
            0:       return 9'h040;
            1:       return 9'h100;
            2:       return 9'h1FC;
            3:       return 9'h1F8;
            default: return {w, 2'b00};
        endcase
    endfunction

    // Monitor: the buffer head must equal the model queue front.
    always @(negedge clk) begin
        if (run && !reset) begin
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                check("instr_out_empty", instr_out, 32'h0);
                check("pc_out_empty", 32'(pc_out), 32'h0);
            end else begin
                check("instr_out", instr_out, exp_q[0].instr);
                check("pc_out", 32'(pc_out), 32'(exp_q[0].pc));
                if (le) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model state
    logic [8:0]  model_pc;
    logic [8:0]  out_addr;
    bit          outstanding, killed, fresh, late_ack, did_reset;
    int          wait_cnt;
    logic        p_redirect, p_ack;
    logic [8:0]  p_target;
    logic [31:0] p_data;

    task automatic check_reset_outputs();
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_pc_out", 32'(pc_out), 32'h0);
        check("rst_imem_req", 32'(imem.imem_req), 32'h0);
    endtask

    initial begin
        int   phase;
        logic ack;
        logic exp_req;

        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        model_pc    = RESET_PC;
        out_addr    = RESET_PC;
        outstanding = 1'b0;
        killed      = 1'b0;
        fresh       = 1'b0;
        late_ack    = 1'b0;
        did_reset   = 1'b0;
        wait_cnt    = 0;
        p_redirect  = 1'b0;
        p_ack       = 1'b0;
        p_target    = 9'h000;
        p_data      = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run   = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Effects of last cycle's inputs at the edge that just passed.
            if (p_redirect) begin
                exp_q.delete();
                model_pc = p_target;
                if (outstanding && !fresh) begin
                    if (p_ack) begin
                        outstanding = 1'b0;
                        killed      = 1'b0;
                    end else begin
                        killed = 1'b1;
                    end
                end
            end else if (outstanding && !fresh && p_ack) begin
                if (!killed) begin
                    exp_q.push_back('{pc: model_pc, instr: p_data});
                    model_pc = model_pc + 9'd4;
                end
                outstanding = 1'b0;
                killed      = 1'b0;
            end
            fresh = 1'b0;

            // One mid-transaction reset, followed by a late ack.
            if (!did_reset && cyc >= 300 && outstanding) begin
                reset         = 1'b1;
                le            = 1'b0;
                redirect      = 1'b0;
                imem.imem_ack = 1'b0;
                exp_q.delete();
                model_pc    = RESET_PC;
                outstanding = 1'b0;
                killed      = 1'b0;
                wait_cnt    = 0;
                @(negedge clk);
                check_reset_outputs();
                @(posedge clk);
                #1;
                reset     = 1'b0;
                late_ack  = 1'b1;
                did_reset = 1'b1;
            end

            phase = (cyc < 20) ? 0 : (cyc < 40) ? 1 : (cyc < 80) ? 2 : 3;

            case (phase)
                0: begin le = 1'b1; redirect = 1'b0; redirect_target = 9'h000; end
                1: begin le = 1'b0; redirect = 1'b0; redirect_target = 9'h000; end
                2: begin
                    le              = 1'($urandom_range(0, 1));
                    redirect        = outstanding && ($urandom_range(0, 3) == 0);
                    redirect_target = 9'h040;
                end
                default: begin
                    le              = ($urandom_range(0, 3) != 0);
                    redirect        = (cyc == 80) || ($urandom_range(0, 7) == 0);
                    redirect_target = (cyc == 80) ? 9'h1FC : pick_target();
                end
            endcase
            #1;

            // Instruction memory
            ack = 1'b0;
            if (outstanding) begin
                check("req_held", 32'(imem.imem_req), 32'h1);
                check("addr_held", 32'(imem.imem_addr), 32'(out_addr));
                if (wait_cnt == 0) ack = 1'b1;
                else               wait_cnt--;
            end else begin
                exp_req = !redirect && (exp_q.size() < 2);
                check("imem_req", 32'(imem.imem_req), 32'(exp_req));
                if (exp_req) begin
                    check("imem_addr", 32'(imem.imem_addr), 32'(model_pc));
                    outstanding = 1'b1;
                    fresh       = 1'b1;
                    out_addr    = model_pc;
                    wait_cnt    = (phase < 2) ? 0 : int'($urandom_range(0, 3));
                end
                // Acks with no live request must be ignored.
                ack = late_ack || (phase == 3 && $urandom_range(0, 7) == 0);
                late_ack = 1'b0;
            end
            imem.imem_ack   = ack;
            imem.imem_rdata = $urandom;

            p_redirect = redirect;
            p_target   = redirect_target;
            p_ack      = ack;
            p_data     = imem.imem_rdata;

            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 9'h000: fetch address loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetch-buffer entries; only 2 is supported.
REQ-003 clk  input  1  clock; the block is rising-edge triggered.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 le  input  1  decode-side load enable; when 1, the consumer takes the buffer head this cycle.
REQ-006 redirect  input  1  branch/jump taken; 1 = restart fetch at redirect_target.
REQ-007 redirect_target  input  9  new fetch byte address.
REQ-008 imem_req  output  1  instruction-memory request, level-held until acknowledged.
REQ-009 imem_addr  output  9  instruction-memory byte address.
REQ-010 imem_ack  input  1  memory read complete; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr_out  output  32  buffer-head instruction; 32'h0 (NOP) when the buffer is empty.
REQ-013 pc_out  output  9  buffer-head PC; 9'h000 when the buffer is empty.
REQ-014 instr_valid  output  1  buffer is non-empty.

Function
REQ-015 fetch_pc register: the address of the next request; it advances by 4 on each acknowledged request and wraps modulo 512.
REQ-016 FSM states: IDLE, WAIT, DISCARD; at most one request is outstanding at any time.
REQ-017 IDLE, redirect=0, count<2: imem_req=1 and imem_addr=fetch_pc in the same cycle (combinational); next state is WAIT.
REQ-018 IDLE, count=2 or redirect=1: imem_req=0.
REQ-019 WAIT: imem_req=1 and imem_addr is held stable until imem_ack.
REQ-020 WAIT, imem_ack=1, redirect=0: push {fetch_pc, imem_rdata}; fetch_pc+=4; next state is IDLE.
REQ-021 WAIT, redirect=1 without imem_ack: flush the buffer; fetch_pc<=redirect_target; next state is DISCARD.
REQ-022 WAIT, redirect=1 with imem_ack: discard the data; flush the buffer; fetch_pc<=redirect_target; next state is IDLE.
REQ-023 DISCARD: imem_req=1 and imem_addr holds the abandoned address; on imem_ack, drop the data and go to IDLE.
REQ-024 DISCARD, redirect=1: fetch_pc<=redirect_target (latest target wins); stay in DISCARD until imem_ack.
REQ-025 IDLE, redirect=1: flush the buffer; fetch_pc<=redirect_target; no request is issued that cycle.
REQ-026 imem_ack in IDLE is ignored.
REQ-027 Pop: when le=1 and instr_valid=1, the head advances at the clock edge.
REQ-028 le=1 with an empty buffer has no effect.
REQ-029 Redirect has priority over pop and push in the same cycle; the buffer is empty on the next cycle.
REQ-030 Push and pop in the same cycle: count is unchanged and order is preserved (FIFO).
REQ-031 Overflow cannot occur: a request is issued only when count<2, and only this block pushes.
REQ-032 Latency: with zero-wait memory (ack in the cycle after the request is issued), the first instruction appears on instr_out 2 cycles after reset release; steady state delivers 1 instruction per 2 cycles.

Reset
REQ-033 Asynchronous reset sets: FSM=IDLE, fetch_pc=RESET_PC, buffer empty (count=0), instr_valid=0, instr_out=32'h0, pc_out=9'h000, imem_req=0.
REQ-034 Reset during WAIT or DISCARD abandons the transaction; a late imem_ack arrives in IDLE and is ignored.

Structure
REQ-035 Shared package contents: PC_W=9, INSTR_W=32, NOP=32'h0, fetch-state enum {IDLE, WAIT, DISCARD}.
REQ-036 Sub-module fetch_fifo: 2-entry {pc, instr} FIFO with push, pop and flush inputs and count/head outputs; flush has priority over push and pop.

Verification
REQ-037 Release reset, ack each request 1 cycle after issue, le=1 -> imem_addr sequence 0,4,8; pc_out/instr_out deliver the same sequence in order.
REQ-038 le=0 with acks immediate -> exactly 2 requests (addr 0,4); imem_req stays 0; instr_valid=1; instr_out unchanged until le=1.
REQ-039 redirect=1, target=9'h040, asserted in WAIT with ack 3 cycles later -> ack data is not delivered; next imem_addr=9'h040; instr_valid=0 until that data returns.
REQ-040 redirect together with imem_ack in WAIT, target=9'h100 -> acked word dropped; next request addr=9'h100, issued the cycle after redirect.
REQ-041 fetch_pc=9'h1FC, acked -> pc_out=9'h1FC, then the next address is 9'h000 (wrap).
REQ-042 Reset asserted in WAIT, late imem_ack after release -> ignored; first request addr=RESET_PC; no spurious instr_valid.
